// File: rtl/mem_bridge_if.sv
// Signal bundle between the CPU memory port, mem_bridge and the physical memory.
// slave: the bridge's view; master: the CPU + memory environment's view.
interface mem_bridge_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  req_ready, rsp_valid, rsp_rdata,
    output mem_rdata, mem_resp, req_valid, req_we, req_addr, req_wdata, req_wmask
  );

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output req_ready, rsp_valid, rsp_rdata,
    input  mem_rdata, mem_resp, req_valid, req_we, req_addr, req_wdata, req_wmask
  );
endinterface

// File: rtl/mem_bridge.sv
// Bridges the level-held multicycle CPU memory port to a valid/ready request + valid-only response memory.
// Optional forced completion of stuck accesses is enabled by defining MEM_TIMEOUT_EN.
module mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd256
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  mem_bridge_if.slave  bus,
  output logic         busy_o,
  output logic         err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic        we_q, we_d;
  logic        req_valid_q, req_valid_d;
  logic        resp_q, resp_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        timeout_s;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 32'd1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Cycles spent in REQ+WAIT for the current access.
  always_comb begin
    if ((state_q == ST_REQ) || (state_q == ST_WAIT)) begin
      cnt_d = cnt_q + CNT_W'(32'd1);
    end else begin
      cnt_d = '0;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the last permitted REQ/WAIT cycle so mem_resp lands TIMEOUT_CYCLES+1 after capture.
  assign timeout_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 32'd1));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and next-output logic; all outputs are registered from these.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    req_valid_d = req_valid_q;
    resp_d      = 1'b0;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          state_d     = ST_REQ;
          addr_d      = {bus.mem_address[31:2], 2'b00};
          we_d        = bus.mem_write;
          wdata_d     = bus.mem_wdata;
          wmask_d     = bus.mem_write ? bus.mem_byte_enable : 4'b0000;
          req_valid_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.req_ready) begin
          state_d     = ST_WAIT;
          req_valid_d = 1'b0;
        end else if (timeout_s) begin
          state_d     = ST_RESP;
          req_valid_d = 1'b0;
          rdata_d     = 32'h0000_0000;
          err_d       = 1'b1;
          resp_d      = 1'b1;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (bus.rsp_valid) begin
          state_d = ST_RESP;
          rdata_d = bus.rsp_rdata;
          resp_d  = 1'b1;
        end else if (timeout_s) begin
          state_d = ST_RESP;
          rdata_d = 32'h0000_0000;
          err_d   = 1'b1;
          resp_d  = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        // CPU request lines are still high here; ignoring them avoids re-issuing the access.
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        req_valid_d = 1'b0;
      end
    endcase
  end

  assign busy_d = (state_d != ST_IDLE);

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      wmask_q     <= 4'b0000;
      we_q        <= 1'b0;
      rdata_q     <= 32'h0000_0000;
      req_valid_q <= 1'b0;
      resp_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      we_q        <= we_d;
      rdata_q     <= rdata_d;
      req_valid_q <= req_valid_d;
      resp_q      <= resp_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_resp  = resp_q;
  assign bus.req_valid = req_valid_q;
  assign bus.req_we    = we_q;
  assign bus.req_addr  = addr_q;
  assign bus.req_wdata = wdata_q;
  assign bus.req_wmask = wmask_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: table of accesses against a cycle-level memory model and
// a response scoreboard, plus hand sequences for stale responses, reset mid-access and timeout.
module tb_mem_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic err;
  int   checks = 0;
  int   errors = 0;

  mem_bridge_if bus ();

  mem_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave),
    .busy_o (busy),
    .err_o  (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          ready_lat;
    int          rsp_lat;
    logic [31:0] rsp_data;
    logic        scramble;
    logic        early;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_mask;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  vec_t vecs [6];
  exp_t sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_resp"},   {31'd0, bus.mem_resp},  32'd0);
    chk({tag, "_rdata"},  bus.mem_rdata,          32'd0);
    chk({tag, "_rvalid"}, {31'd0, bus.req_valid}, 32'd0);
    chk({tag, "_we"},     {31'd0, bus.req_we},    32'd0);
    chk({tag, "_addr"},   bus.req_addr,           32'd0);
    chk({tag, "_wdata"},  bus.req_wdata,          32'd0);
    chk({tag, "_wmask"},  {28'd0, bus.req_wmask}, 32'd0);
    chk({tag, "_busy"},   {31'd0, busy},          32'd0);
    chk({tag, "_err"},    {31'd0, err},           32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int   cyc;
    int   req_cnt;
    int   wait_cnt;
    bit   hs;
    bit   done;
    exp_t e;
    @(posedge clk); #1;
    bus.mem_read        = v.rd;
    bus.mem_write       = v.wr;
    bus.mem_address     = v.addr;
    bus.mem_byte_enable = v.be;
    bus.mem_wdata       = v.wdata;
    e.rdata = v.rsp_data;
    e.lat   = v.exp_lat;
    sb.push_back(e);
    cyc = 0; req_cnt = 0; wait_cnt = 0; hs = 1'b0; done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_rdata = ~v.rsp_data;
      if (bus.mem_resp) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow: got mem_resp with no access pending");
        end else begin
          e = sb.pop_front();
          chk("resp_cycle", cyc, e.lat);
          chk("mem_rdata", bus.mem_rdata, e.rdata);
        end
        chk("req_cycles", req_cnt, v.ready_lat + 1);
        done = 1'b1;
      end else if (bus.req_valid) begin
        chk("req_we",   {31'd0, bus.req_we},    {31'd0, v.exp_we});
        chk("req_addr", bus.req_addr,           v.exp_addr);
        chk("req_mask", {28'd0, bus.req_wmask}, {28'd0, v.exp_mask});
        chk("busy_req", {31'd0, busy},          32'd1);
        if (v.exp_we) chk("req_wdata", bus.req_wdata, v.wdata);
        if (req_cnt == v.ready_lat) begin
          bus.req_ready = 1'b1;
          hs = 1'b1;
          if (v.early) bus.rsp_valid = 1'b1;
        end
        req_cnt++;
      end else if (hs) begin
        if (wait_cnt == v.rsp_lat) begin
          bus.rsp_valid = 1'b1;
          bus.rsp_rdata = v.rsp_data;
        end
        wait_cnt++;
      end
      if (v.scramble && cyc == 1) begin
        bus.mem_address     = ~v.addr;
        bus.mem_wdata       = ~v.wdata;
        bus.mem_byte_enable = ~v.be;
      end
      cyc++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got no mem_resp within %0d cycles expected cycle %0d", cyc, v.exp_lat);
    end
    // CPU drops its request only at the edge that ends the mem_resp cycle.
    @(posedge clk); #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    @(negedge clk);
    chk("resp_single", {31'd0, bus.mem_resp},  32'd0);
    chk("no_reissue",  {31'd0, bus.req_valid}, 32'd0);
    chk("idle_busy",   {31'd0, busy},          32'd0);
    chk("err_clear",   {31'd0, err},           32'd0);
    @(negedge clk);
    chk("no_reissue2", {31'd0, bus.req_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    bus.mem_address = 32'd0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.mem_byte_enable = 4'd0; bus.mem_wdata = 32'd0;
    bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_rdata = 32'd0;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0046, 4'b0000, 32'h0000_0000, 0, 0, 32'hDEAD_BEEF,
                1'b0, 1'b0, 1'b0, 32'h0000_0044, 4'b0000, 3};
    vecs[1] = '{1'b0, 1'b1, 32'h1000_0003, 4'b1100, 32'h1234_5678, 3, 0, 32'hAAAA_5555,
                1'b0, 1'b0, 1'b1, 32'h1000_0000, 4'b1100, 6};
    vecs[2] = '{1'b1, 1'b1, 32'h2000_0008, 4'b0001, 32'hCAFE_F00D, 1, 2, 32'h0BAD_F00D,
                1'b0, 1'b0, 1'b1, 32'h2000_0008, 4'b0001, 6};
    vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 4'b1111, 32'h7777_7777, 0, 4, 32'h1357_9BDF,
                1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 4'b0000, 7};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0001, 4'b0110, 32'h89AB_CDEF, 2, 1, 32'h0000_0000,
                1'b1, 1'b0, 1'b1, 32'h0000_0000, 4'b0110, 6};
    vecs[5] = '{1'b1, 1'b0, 32'h8000_0010, 4'b0000, 32'h0000_0000, 0, 0, 32'h0F0F_0F0F,
                1'b0, 1'b0, 1'b0, 32'h8000_0010, 4'b0000, 3};

    #2;
    check_reset_vals("rst_init");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
    end
    chk("sb_empty", sb.size(), 32'd0);

    // Stale responses while idle must not touch mem_rdata.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.rsp_valid = 1'b1;
      bus.rsp_rdata = 32'h5555_AAAA;
      @(negedge clk);
      bus.rsp_valid = 1'b0;
      chk("stale_rdata", bus.mem_rdata, 32'h0F0F_0F0F);
      chk("stale_resp",  {31'd0, bus.mem_resp}, 32'd0);
      chk("stale_busy",  {31'd0, busy}, 32'd0);
    end

    // Reset while waiting for the response, then a late response after release.
    @(posedge clk); #1;
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h0000_0300;
    @(negedge clk);
    @(negedge clk);
    chk("rw_req_valid", {31'd0, bus.req_valid}, 32'd1);
    bus.req_ready = 1'b1;
    @(negedge clk);
    bus.req_ready = 1'b0;
    chk("rw_busy_wait", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    bus.mem_read = 1'b0;
    #1;
    check_reset_vals("rst_wait");
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_valid = 1'b1;
    bus.rsp_rdata = 32'hFEED_FACE;
    @(negedge clk);
    bus.rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_resp",  {31'd0, bus.mem_resp},  32'd0);
      chk("post_rst_busy",  {31'd0, busy},          32'd0);
      chk("post_rst_rdata", bus.mem_rdata,          32'd0);
      chk("post_rst_valid", {31'd0, bus.req_valid}, 32'd0);
      @(negedge clk);
    end

`ifdef MEM_TIMEOUT_EN
    // Memory never accepts: forced completion 9 cycles after capture with TIMEOUT_CYCLES=8.
    begin
      bit got;
      got = 1'b0;
      @(posedge clk); #1;
      bus.mem_read    = 1'b1;
      bus.mem_address = 32'h0000_0400;
      bus.rsp_rdata   = 32'hBADB_AD00;
      for (int cyc = 0; cyc < 20 && !got; cyc++) begin
        @(negedge clk);
        if (bus.mem_resp) begin
          got = 1'b1;
          chk("to_cycle", cyc, 32'd9);
          chk("to_rdata", bus.mem_rdata, 32'd0);
          chk("to_err",   {31'd0, err}, 32'd1);
          chk("to_valid", {31'd0, bus.req_valid}, 32'd0);
        end else if (cyc >= 1) begin
          chk("to_req_valid", {31'd0, bus.req_valid}, 32'd1);
        end
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL to_no_resp: got no mem_resp expected cycle 9");
      end
      @(posedge clk); #1;
      bus.mem_read = 1'b0;
      repeat (3) @(negedge clk);
      chk("to_err_held", {31'd0, err}, 32'd1);
      chk("to_idle",     {31'd0, busy}, 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
